// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FSM state encodings and the
// bit-period computation used to size the baud counter.
//
// Configuration macro: UART_PARITY_EN (adds the S_Parity state encoding).
// -----------------------------------------------------------------------------
package uart_pkg;

    // FSM state encodings, kept as plain constants so older code can compare
    // against them directly.
    localparam logic [2:0] S_Idle   = 3'd0;
    localparam logic [2:0] S_Start  = 3'd1;
    localparam logic [2:0] S_Data   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_Parity = 3'd3;
`endif
    localparam logic [2:0] S_Stop   = 3'd4;

    // Number of system clocks per line bit (integer division, truncating).
    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/baud_ticker.sv
// -----------------------------------------------------------------------------
// baud_ticker
// Free-running bit-period counter for the UART receiver. The count wraps every
// CyclesPerBit clocks, so consecutive full ticks are exactly one bit apart.
//
// Ports:
//   clock     - system clock
//   reset_n   - asynchronous active-low reset
//   restart   - synchronous clear of the count (dominates wrap)
//   half_tick - high for one cycle at the mid-bit point after a restart
//   full_tick - high for one cycle at the end of every bit period
//
// Requires CyclesPerBit >= 4.
// -----------------------------------------------------------------------------
module baud_ticker #(
    parameter int CyclesPerBit = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int W = $clog2(CyclesPerBit);

    // The receiver sees rx through a 2-flop synchronizer and one more cycle of
    // edge detection before it restarts this counter. Firing the half tick two
    // counts early puts the sample on the true middle of the raw line bit.
    localparam logic [W-1:0] HalfCount = W'(CyclesPerBit / 2 - 2);
    localparam logic [W-1:0] LastCount = W'(CyclesPerBit - 1);

    logic [W-1:0] count;

    // Counter wraps at the bit period; restart re-aligns it to a new edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart || count == LastCount) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign half_tick = (count == HalfCount);
    assign full_tick = (count == LastCount);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Asynchronous serial receiver (8N1 by default). Produces a one-cycle load
// pulse with the received byte on data, suitable to feed the GPZDA parser
// directly.
//
// Parameters:
//   B         - data bits per frame
//   ClockFreq - system clock frequency in Hz
//   BaudRate  - line bit rate in baud
//
// Ports:
//   clock        - system clock
//   reset_n      - asynchronous active-low reset
//   rx           - asynchronous serial line, idle high
//   load         - one-cycle pulse, data holds a new byte
//   data         - last received byte, changes only with load
//   frame_error  - one-cycle pulse when the stop bit reads low
//   parity_error - one-cycle pulse on even-parity mismatch (0 without parity)
//   busy         - high while a frame is in progress
//
// Configuration macro: UART_PARITY_EN (one even-parity bit after the data).
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int B         = 8,
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 9600
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         rx,
    output logic         load,
    output logic [B-1:0] data,
    output logic         frame_error,
    output logic         parity_error,
    output logic         busy
);

    localparam int CyclesPerBit = cycles_per_bit(ClockFreq, BaudRate);
    localparam int IdxW         = (B > 1) ? $clog2(B) : 1;
    localparam logic [IdxW-1:0] LastBit = IdxW'(B - 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [2:0]      state;
    logic [2:0]      next_state;
    logic [IdxW-1:0] bit_idx;
    logic [B-1:0]    shift_reg;
    logic            restart;
    logic            half_tick;
    logic            full_tick;
    logic            parity_ok;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // All flops reset to the idle line level so release never looks like a start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    baud_ticker #(
        .CyclesPerBit(CyclesPerBit)
    ) u_ticker (
        .clock    (clock),
        .reset_n  (reset_n),
        .restart  (restart),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    // Next-state and counter-restart logic. In idle the counter is held clear
    // while the line is high; if the line stays low for a whole bit after a
    // frame (a break), the full tick re-arms reception so a stuck-low line
    // keeps reporting frame errors instead of waiting for an edge forever.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        case (state)
            S_Idle: begin
                restart = rx_sync;
                if ((rx_prev && !rx_sync) || full_tick) begin
                    next_state = S_Start;
                    restart    = 1'b1;
                end
            end
            S_Start: begin
                if (half_tick) begin
                    restart    = 1'b1;
                    next_state = rx_sync ? S_Idle : S_Data;
                end
            end
            S_Data: begin
                if (full_tick && bit_idx == LastBit) begin
`ifdef UART_PARITY_EN
                    next_state = S_Parity;
`else
                    next_state = S_Stop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_Parity: begin
                if (full_tick) begin
                    next_state = S_Stop;
                end
            end
`endif
            S_Stop: begin
                // Leave at mid stop bit so a start edge half a bit later is seen.
                if (full_tick) begin
                    next_state = S_Idle;
                    restart    = 1'b1;
                end
            end
            default: begin
                next_state = S_Idle;
            end
        endcase
    end

    // Main datapath: LSB-first shift register, bit index and the registered
    // result pulses. data only moves on a good stop bit with good parity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_Idle;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            load        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= next_state;
            load        <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                S_Start: begin
                    if (half_tick) begin
                        bit_idx <= '0;
                    end
                end
                S_Data: begin
                    if (full_tick) begin
                        shift_reg <= {rx_sync, shift_reg[B-1:1]};
                        bit_idx   <= bit_idx + IdxW'(1);
                    end
                end
                S_Stop: begin
                    if (full_tick) begin
                        if (!rx_sync) begin
                            frame_error <= 1'b1;
                        end else if (parity_ok) begin
                            load <= 1'b1;
                            data <= shift_reg;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef UART_PARITY_EN
    logic parity_bad;

    // Even parity: data ones plus the parity bit must be even. A bad stop bit
    // outranks a parity mismatch, so the pulse needs a good stop bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_error <= 1'b0;
            if (state == S_Start && half_tick) begin
                parity_bad <= 1'b0;
            end
            if (state == S_Parity && full_tick) begin
                parity_bad <= (^shift_reg) ^ rx_sync;
            end
            if (state == S_Stop && full_tick && rx_sync && parity_bad) begin
                parity_error <= 1'b1;
            end
        end
    end

    assign parity_ok = !parity_bad;
`else
    assign parity_ok    = 1'b1;
    assign parity_error = 1'b0;
`endif

    assign busy = (state != S_Idle);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver at 16 clocks per bit (ClockFreq=16,
// BaudRate=1). Honours UART_PARITY_EN for framing and the parity cases.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int Bit = 16;
`ifdef UART_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    logic       clock;
    logic       reset_n;
    logic       rx;
    logic       load;
    logic [7:0] data;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    int check_count = 0;
    int error_count = 0;

    int cycle        = 0;
    int load_count   = 0;
    int ferr_count   = 0;
    int perr_count   = 0;
    int overlap_count = 0;
    int stray_count  = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_rst  = 1'b0;
    logic [7:0] load_data [$];
    int         load_cycle [$];

    uart_receiver #(
        .B        (8),
        .ClockFreq(16),
        .BaudRate (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .load        (load),
        .data        (data),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clock) begin
        cycle <= cycle + 1;
        if (load) begin
            load_count <= load_count + 1;
            load_data.push_back(data);
            load_cycle.push_back(cycle);
        end
        if (frame_error) ferr_count <= ferr_count + 1;
        if (parity_error) perr_count <= perr_count + 1;
        if ((int'(load) + int'(frame_error) + int'(parity_error)) > 1)
            overlap_count <= overlap_count + 1;
        if (reset_n && prev_rst && !load && data !== prev_data)
            stray_count <= stray_count + 1;
        prev_data <= data;
        prev_rst  <= reset_n;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected)
        else begin
            error_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_bit(input logic value);
        rx = value;
        repeat (Bit) @(negedge clock);
    endtask

    // One frame: start, B data bits LSB first, optional parity, stop.
    task automatic apply_stimulus(input logic [7:0] value, input logic stop_bit,
                                  input logic parity_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(value[i]);
`ifdef UART_PARITY_EN
        send_bit(parity_bit);
`else
        if (parity_bit === 1'bx) $display("[TB] parity bit unknown");
`endif
        send_bit(stop_bit);
    endtask

    initial begin : stimulus
        int l0;
        int f0;
        int p0;
        int n0;
        logic [7:0] msg [6];
        msg[0] = 8'h24; msg[1] = 8'h47; msg[2] = 8'h50;
        msg[3] = 8'h5A; msg[4] = 8'h44; msg[5] = 8'h41;

        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] reset state");
        check_output("reset_load", 32'(load), 32'h0);
        check_output("reset_data", 32'(data), 32'h0);
        check_output("reset_ferr", 32'(frame_error), 32'h0);
        check_output("reset_perr", 32'(parity_error), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (3 * Bit) @(negedge clock);

        $display("[TB] single byte 0x24");
        l0 = load_count; f0 = ferr_count; p0 = perr_count;
        apply_stimulus(8'h24, 1'b1, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        check_output("b24_loads", 32'(load_count - l0), 32'd1);
        check_output("b24_data", 32'(data), 32'h24);
        check_output("b24_ferr", 32'(ferr_count - f0), 32'd0);
        check_output("b24_perr", 32'(perr_count - p0), 32'd0);
        check_output("b24_busy", 32'(busy), 32'h0);

        $display("[TB] bad stop bit on 0x41");
        l0 = load_count; f0 = ferr_count;
        apply_stimulus(8'h41, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        check_output("fe_ferr", 32'(ferr_count - f0), 32'd1);
        check_output("fe_loads", 32'(load_count - l0), 32'd0);
        check_output("fe_data_held", 32'(data), 32'h24);
        check_output("fe_busy", 32'(busy), 32'h0);

        $display("[TB] back-to-back $GPZDA");
        l0 = load_count; f0 = ferr_count; n0 = load_data.size();
        for (int i = 0; i < 6; i++) apply_stimulus(msg[i], 1'b1, ^msg[i]);
        send_bit(1'b1); send_bit(1'b1);
        check_output("msg_loads", 32'(load_count - l0), 32'd6);
        check_output("msg_ferr", 32'(ferr_count - f0), 32'd0);
        if (load_data.size() >= n0 + 6) begin
            for (int i = 0; i < 6; i++)
                check_output($sformatf("msg_data%0d", i), 32'(load_data[n0 + i]), 32'(msg[i]));
            for (int i = 1; i < 6; i++)
                check_output($sformatf("msg_gap%0d", i),
                             32'(load_cycle[n0 + i] - load_cycle[n0 + i - 1]),
                             32'(FrameBits * Bit));
        end

        $display("[TB] 4-cycle glitch");
        l0 = load_count; f0 = ferr_count;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        check_output("glitch_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (8) @(negedge clock);
        check_output("glitch_busy_lo", 32'(busy), 32'h0);
        send_bit(1'b1); send_bit(1'b1);
        check_output("glitch_loads", 32'(load_count - l0), 32'd0);
        check_output("glitch_ferr", 32'(ferr_count - f0), 32'd0);

        $display("[TB] reset during bit 3 of 0x55");
        l0 = load_count; f0 = ferr_count;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rx = 1'b0;
        repeat (Bit / 2) @(negedge clock);
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (4) @(negedge clock);
        check_output("mid_rst_busy", 32'(busy), 32'h0);
        check_output("mid_rst_data", 32'(data), 32'h0);
        reset_n = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        apply_stimulus(8'h5A, 1'b1, ^8'h5A);
        send_bit(1'b1); send_bit(1'b1);
        check_output("mid_rst_loads", 32'(load_count - l0), 32'd1);
        check_output("mid_rst_ferr", 32'(ferr_count - f0), 32'd0);
        check_output("mid_rst_data5a", 32'(data), 32'h5A);

        $display("[TB] line stuck low");
        l0 = load_count; f0 = ferr_count;
        rx = 1'b0;
        repeat (600) @(negedge clock);
        check_output("break_ferr_ge3", 32'((ferr_count - f0) >= 3), 32'h1);
        check_output("break_loads", 32'(load_count - l0), 32'd0);
        rx = 1'b1;
        repeat (12 * Bit) @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        check_output("break_recover_busy", 32'(busy), 32'h0);

`ifdef UART_PARITY_EN
        $display("[TB] parity cases on 0x03");
        l0 = load_count; f0 = ferr_count; p0 = perr_count;
        apply_stimulus(8'h03, 1'b1, 1'b1);
        send_bit(1'b1); send_bit(1'b1);
        check_output("par_bad_perr", 32'(perr_count - p0), 32'd1);
        check_output("par_bad_loads", 32'(load_count - l0), 32'd0);
        check_output("par_bad_ferr", 32'(ferr_count - f0), 32'd0);
        l0 = load_count; p0 = perr_count;
        apply_stimulus(8'h03, 1'b1, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        check_output("par_ok_loads", 32'(load_count - l0), 32'd1);
        check_output("par_ok_perr", 32'(perr_count - p0), 32'd0);
        check_output("par_ok_data", 32'(data), 32'h03);
`else
        check_output("no_parity_pulses", 32'(perr_count), 32'd0);
`endif

        check_output("pulse_overlap", 32'(overlap_count), 32'd0);
        check_output("data_without_load", 32'(stray_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter B, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter ClockFreq, default 100_000_000, meaning clock frequency in Hz.
REQ-003 The block SHALL have parameter BaudRate, default 9600, meaning line bit rate in baud.
REQ-004 The block SHALL have port clock, input, 1, single system clock (100 MHz / 10 ns).
REQ-005 The block SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port rx, input, 1, asynchronous serial line (idle high).
REQ-007 The block SHALL have port load, output, 1, one-cycle pulse meaning data holds a new valid byte.
REQ-008 The block SHALL have port data, output, B, last received byte.
REQ-009 The block SHALL have port frame_error, output, 1, one-cycle pulse on bad stop bit.
REQ-010 The block SHALL have port parity_error, output, 1, one-cycle pulse on parity mismatch (tied 0 without UART_PARITY_EN).
REQ-011 The block SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-012 load/data SHALL directly drive the load/data inputs of the downstream GPZDA parser, no glue.
REQ-013 rx SHALL pass a 2-flop synchronizer (reset value 1); all logic uses the synchronized value.
REQ-014 CyclesPerBit SHALL be ClockFreq/BaudRate (integer division); the bit counter SHALL be $clog2(CyclesPerBit) bits wide.
REQ-015 FSM states SHALL be S_Idle, S_Start, S_Data, S_Parity (only with macro), S_Stop.
REQ-016 S_Idle -> S_Start on synchronized rx high-to-low; the bit counter SHALL clear on entry.
REQ-017 S_Start: at CyclesPerBit/2 cycles rx SHALL be sampled; 0 -> S_Data, 1 -> S_Idle (glitch, no outputs).
REQ-018 S_Data: B samples, each CyclesPerBit cycles after the previous, shifted in LSB first; after bit B-1 -> S_Parity or S_Stop.
REQ-019 S_Stop: sample at mid-bit; 1 -> load pulse and data update on the next clock edge; 0 -> frame_error pulse, data unchanged, no load.
REQ-020 After the stop sample the FSM SHALL return to S_Idle immediately (half-bit early), so a start edge arriving 0.5 bit later is caught.
REQ-021 data SHALL change only together with load; it SHALL hold its value otherwise.
REQ-022 load, frame_error, parity_error SHALL each be high for exactly one cycle per frame, mutually exclusive.
REQ-023 busy SHALL be 1 in every state except S_Idle.
REQ-024 Line held low permanently SHALL produce repeated frame_error, never load, and SHALL NOT hang the FSM.

Reset
REQ-025 reset_n low SHALL asynchronously force state S_Idle, counters 0, shift register 0, data 0, load/frame_error/parity_error/busy 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abort it with no output pulse; reception resumes on the next falling edge after release.

Configuration
REQ-027 Macro UART_PARITY_EN defined: S_Parity SHALL sample one even-parity bit after data; mismatch -> parity_error pulse instead of load at stop time (frame_error takes priority if stop also bad).
REQ-028 UART_PARITY_EN undefined: no S_Parity, 8N1 framing, parity_error constant 0.

Structure
REQ-029 State encoding localparams and the CyclesPerBit computation SHALL live in shared package uart_pkg.
REQ-030 The bit-period counter SHALL be a sub-module baud_ticker (inputs clock, reset_n, restart; outputs half_tick, full_tick).

Verification (ClockFreq=16, BaudRate=1 -> 16 cycles/bit)
REQ-031 Send 0x24 ('$') 8N1 -> exactly one load, data=8'h24, no error pulses, busy low afterwards.
REQ-032 Send "$GPZDA" back-to-back, zero idle gap -> six loads, data 24,47,50,5A,44,41 in order, loads about 160 cycles apart.
REQ-033 Send 0x41 with stop bit 0 -> one frame_error, no load, data keeps previous value.
REQ-034 rx low for 4 cycles then high -> no outputs, busy falls to 0 by cycle 10 after the edge.
REQ-035 Deassert reset_n during bit 3 of 0x55, then send 0x5A -> no pulse for 0x55, single load with data=8'h5A.
REQ-036 With UART_PARITY_EN, send 0x03 with parity bit 1 -> parity_error pulse, no load; parity bit 0 -> load, data=8'h03.
